// File: rtl/saturn_bus_ctrl.sv
// Saturn-style nibble bus controller: turns core LOAD_PC/PC_READ/LOAD_DP/DP_READ requests into
// strobed command/address/read slots (one slot = 2 clocks), with a 4-strobe bus reset after reset.
module saturn_bus_ctrl (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_cmd_valid,
   input  logic [1:0]  i_cmd_op,
   input  logic [19:0] i_cmd_addr,
   output logic        o_cmd_ready,
   output logic        o_data_valid,
   output logic [3:0]  o_data,
   output logic        o_bus_reset,
   output logic        o_bus_clk_en,
   output logic        o_bus_is_data,
   output logic [3:0]  o_bus_nibble_out,
   input  logic [3:0]  i_bus_nibble_in
);

   typedef enum logic [2:0] {
      S_BUS_RESET,
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_READ,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        phase_q, phase_d;
   logic        clk_en_q, clk_en_d;
   logic        pend_q, pend_d;
   logic [1:0]  op_q, op_d;
   logic [19:0] addr_q, addr_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        bus_rst_q, bus_rst_d;
   logic        is_data_q, is_data_d;
   logic [3:0]  nib_q, nib_d;
   logic [3:0]  data_q, data_d;
   logic        dv_q, dv_d;
   logic        accept;
   logic [3:0]  cmd_code;

   // A request accepted mid-slot waits in pend_q for the next slot boundary.
   assign o_cmd_ready = (state_q == S_IDLE) && !pend_q;
   assign accept      = i_cmd_valid && o_cmd_ready;

   always_comb begin
      cmd_code = 4'h4;
      case (op_q)
         2'd0: cmd_code = 4'h4;
         2'd1: cmd_code = 4'h2;
         2'd2: cmd_code = 4'h5;
         2'd3: cmd_code = 4'h3;
         default: cmd_code = 4'h4;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = ~phase_q;
      clk_en_d  = phase_q;
      pend_d    = pend_q;
      op_d      = op_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      bus_rst_d = bus_rst_q;
      is_data_d = is_data_q;
      nib_d     = nib_q;
      data_d    = data_q;
      dv_d      = 1'b0;

      if (accept) begin
         pend_d = 1'b1;
         op_d   = i_cmd_op;
         addr_d = i_cmd_addr;
      end

      // Bus-visible state only moves on the edge that closes a strobe clock.
      if (clk_en_q) begin
         case (state_q)
            S_BUS_RESET: begin
               if (cnt_q == 3'd3) begin
                  state_d   = S_IDLE;
                  cnt_d     = 3'd0;
                  bus_rst_d = 1'b0;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
            S_IDLE: begin
               if (pend_q) begin
                  state_d   = S_CMD;
                  pend_d    = 1'b0;
                  is_data_d = 1'b0;
                  nib_d     = cmd_code;
               end
            end
            S_CMD: begin
               is_data_d = 1'b1;
               cnt_d     = 3'd0;
               if (op_q[0]) begin
                  state_d = S_READ;
                  nib_d   = 4'h0;
               end else begin
                  state_d = S_ADDR;
                  nib_d   = addr_q[3:0];
               end
            end
            S_ADDR: begin
               if (cnt_q == 3'd4) begin
                  state_d   = S_DONE;
                  cnt_d     = 3'd0;
                  is_data_d = 1'b0;
                  nib_d     = 4'h0;
               end else begin
                  cnt_d = cnt_q + 3'd1;
                  nib_d = addr_q[{cnt_d, 2'b00} +: 4];
               end
            end
            S_READ: begin
               data_d    = i_bus_nibble_in;
               dv_d      = 1'b1;
               state_d   = S_DONE;
               is_data_d = 1'b0;
               nib_d     = 4'h0;
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d   = S_BUS_RESET;
               bus_rst_d = 1'b1;
               cnt_d     = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= S_BUS_RESET;
         phase_q   <= 1'b0;
         clk_en_q  <= 1'b0;
         pend_q    <= 1'b0;
         op_q      <= 2'd0;
         addr_q    <= 20'd0;
         cnt_q     <= 3'd0;
         bus_rst_q <= 1'b1;
         is_data_q <= 1'b0;
         nib_q     <= 4'h0;
         data_q    <= 4'h0;
         dv_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         clk_en_q  <= clk_en_d;
         pend_q    <= pend_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         bus_rst_q <= bus_rst_d;
         is_data_q <= is_data_d;
         nib_q     <= nib_d;
         data_q    <= data_d;
         dv_q      <= dv_d;
      end
   end

   assign o_data_valid     = dv_q;
   assign o_data           = data_q;
   assign o_bus_reset      = bus_rst_q;
   assign o_bus_clk_en     = clk_en_q;
   assign o_bus_is_data    = is_data_q;
   assign o_bus_nibble_out = nib_q;

endmodule

// File: tb/tb_saturn_bus_ctrl.sv
// Bench for saturn_bus_ctrl: logs every strobe slot and data pulse, and compares them with the
// slot sequence each operation should produce.
module tb_saturn_bus_ctrl;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_cmd_valid = 1'b0;
   logic [1:0]  i_cmd_op = 2'd0;
   logic [19:0] i_cmd_addr = 20'd0;
   logic [3:0]  i_bus_nibble_in = 4'h0;
   logic        o_cmd_ready, o_data_valid, o_bus_reset, o_bus_clk_en, o_bus_is_data;
   logic [3:0]  o_data, o_bus_nibble_out;

   saturn_bus_ctrl dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd_op(i_cmd_op),
      .i_cmd_addr(i_cmd_addr), .o_cmd_ready(o_cmd_ready), .o_data_valid(o_data_valid),
      .o_data(o_data), .o_bus_reset(o_bus_reset), .o_bus_clk_en(o_bus_clk_en),
      .o_bus_is_data(o_bus_is_data), .o_bus_nibble_out(o_bus_nibble_out),
      .i_bus_nibble_in(i_bus_nibble_in)
   );

   always #5 i_clk = ~i_clk;

   int total = 0, bad = 0, cyc = 0, en_err = 0, rst_strobes = 0;
   bit prev_en = 1'b0, prev_ok = 1'b0;
   logic [3:0] slave_nib = 4'h0;
   bit         slot_isd[$];
   logic [3:0] slot_nib[$];
   int         slot_cyc[$];
   logic [3:0] dv_dat[$];
   int         dv_cyc[$];
   logic [3:0] code_tab [4] = '{4'h4, 4'h2, 4'h5, 4'h3};
   localparam logic [12:0] RST_VEC = {1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};

   // One clock: sample 1 time unit after the edge, log strobes/pulses, play the slave.
   task automatic tick();
      @(posedge i_clk);
      #1;
      cyc++;
      if (o_bus_clk_en) begin
         slot_isd.push_back(o_bus_is_data);
         slot_nib.push_back(o_bus_nibble_out);
         slot_cyc.push_back(cyc);
         if (o_bus_reset) rst_strobes++;
      end
      if (o_data_valid) begin
         dv_dat.push_back(o_data);
         dv_cyc.push_back(cyc);
      end
      if (!i_reset && prev_ok && (o_bus_clk_en == prev_en)) en_err++;
      prev_en = o_bus_clk_en;
      prev_ok = !i_reset;
      i_bus_nibble_in = o_bus_is_data ? slave_nib : 4'($urandom);
   endtask

   task automatic clear_log();
      slot_isd.delete(); slot_nib.delete(); slot_cyc.delete();
      dv_dat.delete(); dv_cyc.delete();
      rst_strobes = 0;
   endtask

   task automatic wait_ready(input int budget);
      int n = 0;
      while (!o_cmd_ready && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic strip_idle(output int lead);
      lead = 0;
      while (slot_isd.size() > 0 && slot_isd[0] == 1'b0 && slot_nib[0] == 4'h0) begin
         void'(slot_isd.pop_front()); void'(slot_nib.pop_front()); void'(slot_cyc.pop_front());
         lead++;
      end
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      repeat (3) tick();
      total++;
      if ({o_bus_reset, o_bus_clk_en, o_bus_is_data, o_bus_nibble_out, o_cmd_ready,
           o_data_valid, o_data} !== RST_VEC)
         begin bad++; $display("FAIL reset_values got=%b want=%b", {o_bus_reset, o_bus_clk_en,
            o_bus_is_data, o_bus_nibble_out, o_cmd_ready, o_data_valid, o_data}, RST_VEC); end
      clear_log();
      i_reset = 1'b0;
      wait_ready(100);
      total++;
      if (rst_strobes !== 4) begin bad++; $display("FAIL reset_strobes got=%0d want=4", rst_strobes); end
      total++;
      if (slot_isd.size() !== 4) begin bad++; $display("FAIL reset_strobe_total got=%0d want=4", slot_isd.size()); end
      total++;
      if ({o_bus_reset, o_cmd_ready} !== 2'b01)
         begin bad++; $display("FAIL reset_exit got bus_reset=%b ready=%b want 0,1", o_bus_reset, o_cmd_ready); end
   endtask

   // Directed LOAD_PC / PC_READ / LOAD_DP-with-noisy-request, then random operations.
   task automatic test_ops();
      logic [1:0]  d_op [3]   = '{2'd0, 2'd1, 2'd2};
      logic [19:0] d_addr [3] = '{20'hABCDE, 20'h00000, 20'h12345};
      for (int i = 0; i < 23; i++) begin
         logic [1:0]  op;
         logic [19:0] addr;
         bit          hold;
         bit          e_isd[$];
         logic [3:0]  e_nib[$];
         int          lead, n;
         op   = (i < 3) ? d_op[i] : 2'($urandom_range(0, 3));
         addr = (i < 3) ? d_addr[i] : 20'($urandom);
         hold = (i == 2) || (i >= 3 && $urandom_range(0, 1) == 1);
         wait_ready(200);
         total++;
         if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL ready_wait op#%0d got=%b want=1", i, o_cmd_ready); end
         clear_log();
         slave_nib = (i == 1) ? 4'h7 : 4'($urandom);
         i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_addr = addr;
         tick();
         total++;
         if (o_cmd_ready !== 1'b0) begin bad++; $display("FAIL ready_drop op#%0d got=%b want=0", i, o_cmd_ready); end
         if (!hold) i_cmd_valid = 1'b0;
         n = 0;
         do begin
            if (hold) begin i_cmd_op = 2'($urandom); i_cmd_addr = 20'($urandom); end
            tick();
            n++;
         end while (!o_cmd_ready && n < 100);
         i_cmd_valid = 1'b0;
         total++;
         if (o_cmd_ready !== 1'b1) begin bad++; $display("FAIL op_done op#%0d ready=%b want=1", i, o_cmd_ready); end

         e_isd.push_back(1'b0); e_nib.push_back(code_tab[op]);
         if (op[0] == 1'b0) begin
            for (int k = 0; k < 5; k++) begin
               e_isd.push_back(1'b1); e_nib.push_back(4'((addr >> (4 * k)) & 20'hF));
            end
         end else begin
            e_isd.push_back(1'b1); e_nib.push_back(4'h0);
         end
         e_isd.push_back(1'b0); e_nib.push_back(4'h0);

         strip_idle(lead);
         total++;
         if (lead > 1) begin bad++; $display("FAIL cmd_start op#%0d idle_slots=%0d want<=1", i, lead); end
         total++;
         if (slot_isd.size() != e_isd.size())
            begin bad++; $display("FAIL slot_count op#%0d got=%0d want=%0d", i, slot_isd.size(), e_isd.size()); end
         else begin
            for (int k = 0; k < e_isd.size(); k++) begin
               total++;
               if (slot_isd[k] !== e_isd[k] || slot_nib[k] !== e_nib[k])
                  begin bad++; $display("FAIL slot op#%0d slot%0d got=%b/%h want=%b/%h", i, k,
                     slot_isd[k], slot_nib[k], e_isd[k], e_nib[k]); end
            end
         end
         total++;
         if (dv_dat.size() != (op[0] ? 1 : 0))
            begin bad++; $display("FAIL dv_count op#%0d got=%0d want=%0d", i, dv_dat.size(), op[0]); end
         else if (op[0] && slot_cyc.size() >= 2) begin
            total++;
            if (dv_dat[0] !== slave_nib) begin bad++; $display("FAIL rd_data op#%0d got=%h want=%h", i, dv_dat[0], slave_nib); end
            total++;
            if (dv_cyc[0] !== slot_cyc[1] + 1)
               begin bad++; $display("FAIL dv_timing op#%0d got=%0d want=%0d", i, dv_cyc[0], slot_cyc[1] + 1); end
         end
      end
   endtask

   task automatic test_reset_abort();
      int n = 0;
      wait_ready(200);
      clear_log();
      i_cmd_valid = 1'b1; i_cmd_op = 2'd2; i_cmd_addr = 20'h12345;
      tick();
      i_cmd_valid = 1'b0;
      while (!(o_bus_is_data === 1'b1 && o_bus_nibble_out === 4'h3) && n < 60) begin
         tick();
         n++;
      end
      total++;
      if (n >= 60) begin bad++; $display("FAIL abort_reach got=timeout want=addr slot 3"); end
      i_reset = 1'b1;
      #1;
      total++;
      if ({o_bus_reset, o_bus_clk_en, o_bus_is_data, o_bus_nibble_out, o_cmd_ready,
           o_data_valid, o_data} !== RST_VEC)
         begin bad++; $display("FAIL abort_values got=%b want=%b", {o_bus_reset, o_bus_clk_en,
            o_bus_is_data, o_bus_nibble_out, o_cmd_ready, o_data_valid, o_data}, RST_VEC); end
      repeat (2) tick();
      slot_isd.delete(); slot_nib.delete(); slot_cyc.delete();
      rst_strobes = 0;
      i_reset = 1'b0;
      wait_ready(100);
      total++;
      if (rst_strobes !== 4) begin bad++; $display("FAIL abort_reseq got=%0d want=4", rst_strobes); end
      total++;
      if ({o_bus_reset, o_cmd_ready} !== 2'b01)
         begin bad++; $display("FAIL abort_exit got bus_reset=%b ready=%b want 0,1", o_bus_reset, o_cmd_ready); end
      total++;
      if (dv_dat.size() !== 0) begin bad++; $display("FAIL abort_dv got=%0d want=0", dv_dat.size()); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_dat[$];
      bit         p_isd [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [3:0] p_nib [4] = '{4'h3, 4'h0, 4'h0, 4'h0};
      int n = 0, lead, seen;
      wait_ready(200);
      clear_log();
      en_err = 0;
      slave_nib = 4'($urandom);
      exp_dat.push_back(slave_nib);
      i_cmd_valid = 1'b1; i_cmd_op = 2'd3; i_cmd_addr = 20'($urandom);
      seen = 0;
      while (dv_dat.size() < 4 && n < 200) begin
         tick();
         n++;
         if (dv_dat.size() > seen) begin
            seen = dv_dat.size();
            slave_nib = 4'($urandom);
            exp_dat.push_back(slave_nib);
         end
      end
      i_cmd_valid = 1'b0;
      total++;
      if (dv_dat.size() !== 4) begin bad++; $display("FAIL b2b_dv_count got=%0d want=4", dv_dat.size()); end
      for (int k = 0; k < dv_dat.size(); k++) begin
         total++;
         if (dv_dat[k] !== exp_dat[k]) begin bad++; $display("FAIL b2b_data op%0d got=%h want=%h", k, dv_dat[k], exp_dat[k]); end
         if (k > 0) begin
            total++;
            if (dv_cyc[k] - dv_cyc[k-1] !== 8)
               begin bad++; $display("FAIL b2b_spacing op%0d got=%0d want=8", k, dv_cyc[k] - dv_cyc[k-1]); end
         end
      end
      strip_idle(lead);
      total++;
      if (slot_isd.size() < 14) begin bad++; $display("FAIL b2b_slots got=%0d want>=14", slot_isd.size()); end
      else begin
         for (int k = 0; k < 14; k++) begin
            total++;
            if (slot_isd[k] !== p_isd[k % 4] || slot_nib[k] !== p_nib[k % 4])
               begin bad++; $display("FAIL b2b_slot%0d got=%b/%h want=%b/%h", k, slot_isd[k],
                  slot_nib[k], p_isd[k % 4], p_nib[k % 4]); end
         end
      end
      total++;
      if (en_err !== 0) begin bad++; $display("FAIL b2b_strobe_period errors=%0d want=0", en_err); end
      wait_ready(100);
   endtask

   initial begin
      #1;
      test_reset();
      test_ops();
      test_reset_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/saturn_bus_ctrl.md
SATURN_BUS_CTRL -- requirements
Module: saturn_bus_ctrl

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: single system clock; all state on rising edge.
REQ-002 SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port i_cmd_valid, input, 1 bit: core requests a bus operation.
REQ-004 SHALL have port i_cmd_op, input, 2 bits: operation code; 00 LOAD_PC, 01 PC_READ, 10 LOAD_DP, 11 DP_READ.
REQ-005 SHALL have port i_cmd_addr, input, 20 bits: address for LOAD_PC/LOAD_DP; ignored otherwise.
REQ-006 SHALL have port o_cmd_ready, output, 1 bit: controller idle and able to accept an operation.
REQ-007 SHALL have port o_data_valid, output, 1 bit: one-clock pulse qualifying o_data.
REQ-008 SHALL have port o_data, output, 4 bits: nibble returned by a read operation.
REQ-009 SHALL have port o_bus_reset, output, 1 bit: bus reset to all bus slaves.
REQ-010 SHALL have port o_bus_clk_en, output, 1 bit: bus strobe; slaves sample or drive on this cycle.
REQ-011 SHALL have port o_bus_is_data, output, 1 bit: 1 = current slot is data/address, 0 = command nibble.
REQ-012 SHALL have port o_bus_nibble_out, output, 4 bits: nibble driven to slaves.
REQ-013 SHALL have port i_bus_nibble_in, input, 4 bits: nibble returned by slaves.

Function
REQ-014 SHALL toggle an internal phase bit every clock; o_bus_clk_en registered, high on every second clock (1-clock pulse, period 2).
REQ-015 SHALL define a bus slot as two clocks ending with an o_bus_clk_en-high clock; o_bus_reset, o_bus_is_data, o_bus_nibble_out change only on the edge closing a strobe cycle, stable for a full slot.
REQ-016 SHALL implement states BUS_RESET, IDLE, CMD, ADDR, READ, DONE.
REQ-017 SHALL, after reset release, stay in BUS_RESET with o_bus_reset=1 for exactly 4 strobes, then deassert o_bus_reset at the slot boundary and enter IDLE.
REQ-018 SHALL assert o_cmd_ready only in IDLE; accept when i_cmd_valid && o_cmd_ready on a clock edge, capturing op and addr; o_cmd_ready low from next clock.
REQ-019 SHALL, in IDLE, drive o_bus_is_data=0, o_bus_nibble_out=0.
REQ-020 SHALL start CMD at the first slot boundary after accept: o_bus_is_data=0, o_bus_nibble_out = 4 (LOAD_PC), 2 (PC_READ), 5 (LOAD_DP), 3 (DP_READ).
REQ-021 SHALL, for LOAD_PC/LOAD_DP, follow CMD with 5 ADDR slots, o_bus_is_data=1, captured address least-significant nibble first (bits 3:0 ... 19:16).
REQ-022 SHALL, for PC_READ/DP_READ, follow CMD with 1 READ slot: o_bus_is_data=1, o_bus_nibble_out=0; sample i_bus_nibble_in on the READ slot's strobe clock into o_data.
REQ-023 SHALL pulse o_data_valid for exactly one clock, the clock after the READ sample; o_data holds until next read sample.
REQ-024 SHALL, after the last slot of any op, pass through DONE (one slot, bus idle values) and return to IDLE; o_cmd_ready high from first IDLE clock.
REQ-025 SHALL ignore i_cmd_valid, i_cmd_op, i_cmd_addr while o_cmd_ready=0; changes to captured values SHALL NOT affect an op in flight.
REQ-026 SHALL never pulse o_data_valid for LOAD_PC/LOAD_DP.
REQ-027 SHALL, on i_reset assertion mid-operation, abort immediately with no further data pulse and restart at BUS_RESET on release.

Reset
REQ-028 SHALL, while i_reset=1, hold o_bus_reset=1, o_bus_clk_en=0, o_bus_is_data=0, o_bus_nibble_out=0, o_cmd_ready=0, o_data_valid=0, o_data=0, phase=0, state BUS_RESET.

Verification
REQ-029 Reset release -> exactly 4 o_bus_clk_en pulses with o_bus_reset=1, then o_bus_reset=0, o_cmd_ready=1.
REQ-030 LOAD_PC addr 20'hABCDE -> slot nibbles 4(is_data=0), E,D,C,B,A(is_data=1), DONE slot, o_cmd_ready=1; no o_data_valid.
REQ-031 PC_READ with slave returning 4'h7 in READ slot -> nibbles 2(is_data=0), 0(is_data=1); o_data=4'h7, one-clock o_data_valid the clock after READ strobe.
REQ-032 i_cmd_valid held high with different ops during LOAD_DP 20'h12345 -> bus shows 5,5,4,3,2,1 unaltered; next op accepted only when o_cmd_ready=1.
REQ-033 i_reset pulsed during ADDR slot 3 of LOAD_DP -> all outputs at reset values same cycle; after release, 4-strobe bus reset sequence repeats, no o_data_valid.
REQ-034 Back-to-back DP_READ ops with i_cmd_valid constant high -> each op 3 slots (CMD, READ, DONE), o_data_valid once per op, o_bus_clk_en period 2 throughout.
